// File: rtl/trans_pingpong_buffer.sv
// Double-banked transition buffer: the producing layer fills one bank while the
// consuming layer reads the other; banks swap on end-of-layer pulses.
//
// bank state | meaning
// FREE (0)   | bank may be written by the producer
// FULL (1)   | bank holds a complete frame, waiting for or being read by the consumer
module trans_pingpong_buffer #(
  parameter int N_adder_tree = 16,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_adder_tree*16-1:0] wr_data,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic                      wr_en,
  input  logic                      wr_done,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [N_adder_tree*16-1:0] rd_data,
  output logic                      rd_start,
  input  logic                      rd_done,
  output logic [1:0]                frames_pending,
  output logic                      ovf_err
);

  localparam int W = N_adder_tree * 16;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0] mem [2][DEPTH];

  logic [1:0] full_q, full_d;
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d;
  logic       ovf_q, ovf_d;

  logic       wr_addr_ok, rd_addr_ok, wr_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= 2'b00;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    ovf_d   = ovf_q;

    if (wr_en && (!wr_ready || !wr_addr_ok))
      ovf_d = 1'b1;

    if (rd_done && busy_q) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
      busy_d       = 1'b0;
    end else if (!busy_q && full_q[rb_q]) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
    end

    if (wr_done) begin
      if (wr_ready)
        full_d[wb_q] = 1'b1;
      else
        ovf_d = 1'b1;
    end

    // Covers both the immediate swap on wr_done and the release of a stalled
    // writer; a bank freed by rd_done this edge already counts as free.
    if (full_d[wb_q] && !full_d[~wb_q])
      wb_d = ~wb_q;
  end

  always_comb begin
    wr_addr_ok     = {1'b0, wr_addr} < DEPTH_L;
    rd_addr_ok     = {1'b0, rd_addr} < DEPTH_L;
    wr_ready       = !full_q[wb_q];
    wr_fire        = wr_en && wr_ready && wr_addr_ok;
    rd_start       = start_q;
    ovf_err        = ovf_q;
    frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wb_q][wr_addr] <= wr_data;
  end

  // Non-blocking write above makes a same-bank same-address read see old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data <= '0;
    else if (rd_addr_ok)
      rd_data <= mem[rb_q][rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_trans_pingpong_buffer.sv
// Directed bench for trans_pingpong_buffer: reset, single frame, ping-pong stall,
// overflow, address bounds, simultaneous done pulses and mid-operation reset.
module tb_trans_pingpong_buffer;

  localparam int NL = 2;
  localparam int AW = 5;
  localparam int DP = 24;
  localparam int W  = NL * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_en = 1'b0;
  logic          wr_done = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_start;
  logic          rd_done = 1'b0;
  logic [1:0]    frames_pending;
  logic          ovf_err;

  int total = 0;
  int bad   = 0;

  trans_pingpong_buffer #(.N_adder_tree(NL), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .wr_done(wr_done),
    .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_start(rd_start), .rd_done(rd_done),
    .frames_pending(frames_pending), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // lane = {tag+addr, addr}; tag 0 gives addr*0x0101 in every lane
  function automatic logic [W-1:0] pat(input logic [7:0] tag, input logic [7:0] a);
    logic [15:0] l;
    l[15:8] = tag + a;
    l[7:0]  = a;
    return {NL{l}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b0; wr_en = 1'b0; wr_done = 1'b0; rd_done = 1'b0; rd_addr = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic write_frame(input logic [7:0] tag, input int n);
    for (int a = 0; a < n; a++) begin
      wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = pat(tag, a[7:0]);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_wr_done;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
  endtask

  task automatic pulse_rd_done;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_hold_rd_data got=%h exp=0", rd_data); end
    rst = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL rst_rd_start got=%b exp=0", rd_start); end
    total++; if (frames_pending !== 2'd0) begin bad++; $display("FAIL rst_frames got=%0d exp=0", frames_pending); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf_err); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_single_frame;
    write_frame(8'h00, 8);
    pulse_wr_done();
    total++; if (frames_pending !== 2'd1) begin bad++; $display("FAIL sf_frames got=%0d exp=1", frames_pending); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL sf_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL sf_start_early got=%b exp=0", rd_start); end
    rd_addr = 5;
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL sf_start got=%b exp=1", rd_start); end
    tick();
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL sf_start_width got=%b exp=0", rd_start); end
    total++; if (rd_data !== 32'h0505_0505) begin bad++; $display("FAIL sf_rd_data got=%h exp=05050505", rd_data); end
    pulse_rd_done();
    total++; if (frames_pending !== 2'd0) begin bad++; $display("FAIL sf_frames_after got=%0d exp=0", frames_pending); end
    tick();
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL sf_no_restart got=%b exp=0", rd_start); end
  endtask

  task automatic test_pingpong_overflow;
    write_frame(8'hA0, 4);
    pulse_wr_done();
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL pp_start_a got=%b exp=1", rd_start); end
    write_frame(8'hB0, 4);
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL pp_busy_no_start got=%b exp=0", rd_start); end
    pulse_wr_done();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL pp_stall_ready got=%b exp=0", wr_ready); end
    total++; if (frames_pending !== 2'd2) begin bad++; $display("FAIL pp_frames2 got=%0d exp=2", frames_pending); end
    rd_addr = 2;
    tick();
    total++; if (rd_data !== 32'hA202_A202) begin bad++; $display("FAIL pp_read_a got=%h exp=a202a202", rd_data); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL pp_ovf_pre got=%b exp=0", ovf_err); end
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_full_write got=%b exp=1", ovf_err); end
    pulse_rd_done();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL pp_unstall_ready got=%b exp=1", wr_ready); end
    total++; if (frames_pending !== 2'd1) begin bad++; $display("FAIL pp_frames1 got=%0d exp=1", frames_pending); end
    rd_addr = 3;
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL pp_start_b got=%b exp=1", rd_start); end
    total++; if (rd_data !== 32'hB303_B303) begin bad++; $display("FAIL pp_read_b got=%h exp=b303b303", rd_data); end
    pulse_rd_done();
    total++; if (frames_pending !== 2'd0) begin bad++; $display("FAIL pp_frames0 got=%0d exp=0", frames_pending); end
  endtask

  task automatic test_addr_bounds;
    apply_reset();
    wr_en = 1'b1; wr_addr = AW'(DP - 1); wr_data = 32'h1234_5678;
    tick();
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ab_last_addr_ovf got=%b exp=0", ovf_err); end
    rd_addr = AW'(DP - 1); wr_data = 32'h8765_4321;
    tick();
    wr_en = 1'b0;
    total++; if (rd_data !== 32'h1234_5678) begin bad++; $display("FAIL ab_read_before_write got=%h exp=12345678", rd_data); end
    tick();
    total++; if (rd_data !== 32'h8765_4321) begin bad++; $display("FAIL ab_read_new got=%h exp=87654321", rd_data); end
    rd_addr = AW'(DP);
    tick();
    total++; if (rd_data !== '0) begin bad++; $display("FAIL ab_read_oob got=%h exp=0", rd_data); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ab_read_oob_ovf got=%b exp=0", ovf_err); end
    wr_en = 1'b1; wr_addr = AW'(DP); wr_data = 32'hFFFF_FFFF;
    tick();
    wr_en = 1'b0;
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ab_write_oob_ovf got=%b exp=1", ovf_err); end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    write_frame(8'h10, 2);
    pulse_wr_done();
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL sim_start0 got=%b exp=1", rd_start); end
    write_frame(8'hC0, 2);
    wr_done = 1'b1; rd_done = 1'b1;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL sim_wr_ready got=%b exp=1", wr_ready); end
    total++; if (frames_pending !== 2'd1) begin bad++; $display("FAIL sim_frames got=%0d exp=1", frames_pending); end
    rd_addr = 1;
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL sim_start1 got=%b exp=1", rd_start); end
    total++; if (rd_data !== 32'hC101_C101) begin bad++; $display("FAIL sim_read1 got=%h exp=c101c101", rd_data); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL sim_ovf got=%b exp=0", ovf_err); end
  endtask

  task automatic test_reset_mid;
    write_frame(8'h20, 2);
    #2;
    rst = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mid_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_start !== 1'b0) begin bad++; $display("FAIL mid_rd_start got=%b exp=0", rd_start); end
    total++; if (frames_pending !== 2'd0) begin bad++; $display("FAIL mid_frames got=%0d exp=0", frames_pending); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL mid_rd_data got=%h exp=0", rd_data); end
    repeat (2) tick();
    rst = 1'b1;
    #1;
    write_frame(8'h00, 8);
    pulse_wr_done();
    total++; if (frames_pending !== 2'd1) begin bad++; $display("FAIL mid_sf_frames got=%0d exp=1", frames_pending); end
    rd_addr = 6;
    tick();
    total++; if (rd_start !== 1'b1) begin bad++; $display("FAIL mid_sf_start got=%b exp=1", rd_start); end
    total++; if (rd_data !== 32'h0606_0606) begin bad++; $display("FAIL mid_sf_read got=%h exp=06060606", rd_data); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pingpong_overflow();
    test_addr_bounds();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trans_pingpong_buffer.md
Name: trans_pingpong_buffer

Overview:
- Double-banked transition buffer between two layer engines.
- Write side accepts the producing layer's output stream (word, address, load strobe, end-of-layer pulse).
- Read side serves the consuming layer's transition-read port with 1-cycle registered latency, and issues a start pulse once a full bank is available.
- Bank swap lets layer N write frame k+1 while layer N+1 reads frame k.

Parameters:
- N_adder_tree, 16, lanes per word; word width = N_adder_tree*16.
- ADDR_W, 10, address width per bank.
- DEPTH, 1024, words per bank (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_data  in  N_adder_tree*16  producer output word.
- wr_addr  in  ADDR_W  producer write address.
- wr_en  in  1  producer load strobe; write when wr_en=1 and wr_ready=1.
- wr_done  in  1  producer end-of-layer pulse (1 cycle).
- wr_ready  out  1  current write bank is FREE/FILLING and accepts data.
- rd_addr  in  ADDR_W  consumer transition-read address.
- rd_data  out  N_adder_tree*16  registered word from read bank.
- rd_start  out  1  1-cycle pulse: read bank holds a complete frame.
- rd_done  in  1  consumer end-of-layer pulse (1 cycle).
- frames_pending  out  2  number of FULL banks (0..2).
- ovf_err  out  1  sticky: write attempted while wr_ready=0, or address >= DEPTH.

Behaviour:
- Reset (rst=0, async): both banks FREE, wb=0, rb=0, rd_busy=0. Outputs: wr_ready=1, rd_data=0, rd_start=0, frames_pending=0, ovf_err=0. Memory contents are not cleared.
- Bank state per bank: FREE -> FULL on wr_done while that bank is wb. FULL -> FREE on rd_done while that bank is rb and rd_busy=1.
- Write path: when wr_en=1, wr_ready=1 and wr_addr<DEPTH, write wr_data into bank wb at wr_addr this edge.
  - wr_en=1 with wr_ready=0 is dropped and sets ovf_err.
  - wr_addr>=DEPTH is dropped and sets ovf_err.
- wr_done handling: bank wb is marked FULL.
  - If the other bank is FREE at that edge, wb toggles the same edge.
  - Otherwise wb holds, wr_ready=0 until the other bank frees, then wb toggles and wr_ready=1 on the next edge.
  - wr_done while wr_ready=0 is ignored and sets ovf_err.
- wr_ready = (state[wb]==FREE), registered.
- Read start: when rd_busy=0 and state[rb]==FULL, assert rd_start for exactly one cycle and set rd_busy=1 on the same edge. rd_start never re-fires while rd_busy=1.
- Read data: rd_data <= bank[rb][rd_addr] each edge (latency 1). Reads are not gated by bank state.
  - rd_addr>=DEPTH returns 0. ovf_err is not set for reads.
- rd_done handling: with rd_busy=1, bank rb -> FREE, rb toggles, rd_busy=0. Earliest next rd_start is 1 cycle later.
  - rd_done with rd_busy=0 is ignored.
- Simultaneous wr_done and rd_done in one cycle: both apply. A bank freed by rd_done counts as FREE for that same edge's wr_done swap decision, so no stall.
- Same-bank read/write in one cycle cannot happen (wb != rb while rd_busy=1). If it does occur (wb==rb, rd_busy=0), the read returns old data (read-before-write).
- frames_pending = count of FULL banks, registered, updated the same edge as state changes.
- Reset mid-operation: everything returns to reset values within the reset assertion; in-flight frames are discarded.

Test Plan:
- Reset check: rst low 3 cycles, release -> wr_ready=1, rd_start=0, frames_pending=0, ovf_err=0, rd_data=0.
- Single frame: write addr 0..7 with data = addr*0x0101 in every lane, then wr_done -> next cycle rd_start=1 for 1 cycle, frames_pending=1. Read addr 5 -> rd_data lane0 = 0x0505 one cycle later.
- Ping-pong: write frame A, wr_done; write frame B (rd_busy on A), wr_done -> wr_ready=0, frames_pending=2. rd_done -> wr_ready=1 the next cycle, rd_start pulses for B, reads return B data.
- Overflow: with both banks FULL, pulse wr_en at addr 3 -> ovf_err=1 and bank contents unchanged. Write to addr DEPTH -> dropped, ovf_err=1.
- Simultaneous: bank 0 busy reading, bank 1 filling; assert wr_done and rd_done the same cycle -> no stall (wr_ready stays 1), frames_pending stays 1, rd_start fires for bank 1 the following cycle.
- Reset mid-operation: during frame-B write with frame A busy, drop rst -> all outputs return to reset values immediately; after release, a new single frame behaves as in the single-frame test.
